// File: rtl/bus_arbiter.sv
// Round-robin, dead-cycle, hold-limited arbiter for the shared 8-bit CPU bus.
// Optional waiting-cycle counter enabled by defining BUS_ARB_CONTENTION_EN.
module bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 15,
  parameter int CW       = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req,
  output logic [NUM_REQ-1:0]                    grant,
  output logic                                  grant_valid,
  output logic [(NUM_REQ>1?$clog2(NUM_REQ):1)-1:0] grant_id,
  output logic                                  bus_idle,
  output logic                                  preempt
`ifdef BUS_ARB_CONTENTION_EN
  ,
  input  logic                                  cnt_clr,
  output logic [CW-1:0]                         contention_cnt
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [IW-1:0]     ptr_r;
  logic [IW-1:0]     ptr_nxt_s;
  logic [CW-1:0]     hold_cnt_r;
  logic [CW-1:0]     hold_nxt_s;
  logic [NUM_REQ-1:0] grant_r;
  logic [NUM_REQ-1:0] grant_nxt_s;
  logic [IW-1:0]     grant_id_r;
  logic [IW-1:0]     id_nxt_s;
  logic              grant_valid_r;
  logic              bus_idle_r;
  logic              preempt_r;
  logic              preempt_nxt_s;

  logic              any_req_s;
  logic              others_s;
  logic              owner_req_s;
  logic              hold_lim_s;
  logic [IW-1:0]     pick_s;

  // First requester at or above p, wrapping; descending scan so the nearest wins.
  function automatic logic [IW-1:0] pick_f(input logic [NUM_REQ-1:0] r,
                                           input logic [IW-1:0] p);
    logic [IW-1:0] sel;
    int            j;
    sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(p) + i;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end else begin
        j = j;
      end
      if (r[j]) begin
        sel = IW'(j);
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  assign any_req_s   = |req;
  assign others_s    = |(req & ~grant_r);
  assign owner_req_s = req[grant_id_r];
  assign hold_lim_s  = (hold_cnt_r >= CW'(MAX_HOLD - 1));
  assign pick_s      = pick_f(req, ptr_r);

  // State and registered-output storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      ptr_r         <= '0;
      hold_cnt_r    <= '0;
      grant_r       <= '0;
      grant_id_r    <= '0;
      grant_valid_r <= 1'b0;
      bus_idle_r    <= 1'b1;
      preempt_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      ptr_r         <= ptr_nxt_s;
      hold_cnt_r    <= hold_nxt_s;
      grant_r       <= grant_nxt_s;
      grant_id_r    <= id_nxt_s;
      grant_valid_r <= |grant_nxt_s;
      bus_idle_r    <= ~(|grant_nxt_s);
      preempt_r     <= preempt_nxt_s;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_nxt_s = OWN;
        else           state_nxt_s = IDLE;
      end
      OWN: begin
        if (!owner_req_s)                state_nxt_s = TURN;
        else if (hold_lim_s && others_s) state_nxt_s = TURN;
        else                             state_nxt_s = OWN;
      end
      TURN: begin
        if (any_req_s) state_nxt_s = OWN;
        else           state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant, pointer, hold-timer and preempt values for the next cycle.
  always_comb begin
    grant_nxt_s   = grant_r;
    id_nxt_s      = grant_id_r;
    preempt_nxt_s = 1'b0;
    hold_nxt_s    = hold_cnt_r;
    ptr_nxt_s     = ptr_r;
    case (state_r)
      IDLE, TURN: begin
        hold_nxt_s = '0;
        if (any_req_s) begin
          grant_nxt_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
          id_nxt_s    = pick_s;
          if (pick_s == IW'(NUM_REQ - 1)) ptr_nxt_s = '0;
          else                            ptr_nxt_s = pick_s + IW'(1);
        end else begin
          grant_nxt_s = '0;
          id_nxt_s    = '0;
        end
      end
      OWN: begin
        if (hold_cnt_r == {CW{1'b1}}) hold_nxt_s = hold_cnt_r;
        else                          hold_nxt_s = hold_cnt_r + CW'(1);
        // A voluntary drop on the limit cycle is a plain release, not a preempt.
        if (!owner_req_s) begin
          grant_nxt_s = '0;
          id_nxt_s    = '0;
        end else if (hold_lim_s && others_s) begin
          grant_nxt_s   = '0;
          id_nxt_s      = '0;
          preempt_nxt_s = 1'b1;
        end else begin
          grant_nxt_s = grant_r;
        end
      end
      default: begin
        grant_nxt_s = '0;
        id_nxt_s    = '0;
        hold_nxt_s  = '0;
      end
    endcase
  end

  assign grant       = grant_r;
  assign grant_id    = grant_id_r;
  assign grant_valid = grant_valid_r;
  assign bus_idle    = bus_idle_r;
  assign preempt     = preempt_r;

`ifdef BUS_ARB_CONTENTION_EN
  logic [CW-1:0] contention_r;
  logic          multi_req_s;

  // Two or more bits set leaves a nonzero residue after clearing the lowest one.
  assign multi_req_s = |(req & (req - NUM_REQ'(1)));

  // Saturating count of cycles with someone waiting; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contention_r <= '0;
    end else if (cnt_clr) begin
      contention_r <= '0;
    end else if (multi_req_s && (contention_r != {CW{1'b1}})) begin
      contention_r <= contention_r + CW'(1);
    end else begin
      contention_r <= contention_r;
    end
  end

  assign contention_cnt = contention_r;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter (NUM_REQ=4, MAX_HOLD=3).
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       bus_idle;
  logic       preempt;
`ifdef BUS_ARB_CONTENTION_EN
  logic       cnt_clr;
  logic [7:0] contention_cnt;
`endif

  int checks;
  int failures;

  bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(3), .CW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .bus_idle    (bus_idle),
    .preempt     (preempt)
`ifdef BUS_ARB_CONTENTION_EN
    ,
    .cnt_clr        (cnt_clr),
    .contention_cnt (contention_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle invariants: one-hot, dead cycle between owners, id matches grant.
  logic [3:0] prev_grant;
  initial prev_grant = 4'b0000;
  always @(negedge clk) begin
    if (!rst) begin
      logic [1:0] exp_id;
      exp_id = 2'd0;
      for (int k = 0; k < 4; k++) if (grant[k]) exp_id = 2'(k);
      check("onehot", 32'($countones(grant) <= 1), 32'd1);
      check("dead_cycle", 32'((prev_grant != 4'b0000) && (grant != 4'b0000)
                              && (grant != prev_grant)), 32'd0);
      check("id_match", 32'(grant_id), 32'(exp_id));
      check("valid_idle", 32'({grant_valid, bus_idle}), (grant != 4'b0000) ? 32'd2 : 32'd1);
    end
    prev_grant = rst ? 4'b0000 : grant;
  end

  initial begin
    logic [3:0] exp_g;
    int         npre;
    int         bad_g;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 4'b0000;
`ifdef BUS_ARB_CONTENTION_EN
    cnt_clr  = 1'b0;
`endif

    // Reset and single requester.
    tick(); tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_idle", 32'(bus_idle), 32'd1);
    check("rst_id", 32'(grant_id), 32'd0);
    check("rst_preempt", 32'(preempt), 32'd0);
    rst = 1'b0;
    req = 4'b0010;
    tick();
    check("single_grant", 32'(grant), 32'h2);
    check("single_id", 32'(grant_id), 32'd1);
    req = 4'b0000;
    tick();
    check("release_turn", 32'(grant), 32'h0);
    check("release_nopre", 32'(preempt), 32'd0);
    tick();
    check("release_idle_state", 32'(dut.state_r), 32'd0);
    check("release_bus_idle", 32'(bus_idle), 32'd1);

    // Round robin under full load, starting from ptr=0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    npre = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      exp_g = ((i % 4) == 3) ? 4'b0000 : (4'b0001 << ((i / 4) % 4));
      check("rr_grant", 32'(grant), 32'(exp_g));
      check("rr_preempt", 32'(preempt), ((i % 4) == 3) ? 32'd1 : 32'd0);
      if (preempt) npre++;
    end
    check("rr_preempt_count", 32'(npre), 32'd4);

    // Sole requester is never preempted; the hold timer saturates.
    req   = 4'b0001;
    bad_g = 0;
    npre  = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (grant != 4'b0001) bad_g++;
      if (preempt) npre++;
    end
    check("solo_grant_bad", 32'(bad_g), 32'd0);
    check("solo_preempt", 32'(npre), 32'd0);
    check("solo_hold_sat", 32'(dut.hold_cnt_r), 32'd255);

    // Owner 2 drops on the limit cycle while requester 0 waits.
    req = 4'b0000;
    tick(); tick();
    req = 4'b0100;
    tick();
    check("vol_grant2", 32'(grant), 32'h4);
    req = 4'b0101;
    tick(); tick();
    check("vol_hold", 32'(dut.hold_cnt_r), 32'd2);
    check("vol_still2", 32'(grant), 32'h4);
    req = 4'b0001;
    tick();
    check("vol_turn", 32'(grant), 32'h0);
    check("vol_nopre", 32'(preempt), 32'd0);
    tick();
    check("vol_grant0", 32'(grant), 32'h1);

    // Asynchronous reset while requester 2 owns the bus.
    req = 4'b0100;
    tick(); tick();
    check("ar_grant2", 32'(grant), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("ar_grant_clr", 32'(grant), 32'h0);
    check("ar_bus_idle", 32'(bus_idle), 32'd1);
    check("ar_ptr", 32'(dut.ptr_r), 32'd0);
    #1 rst = 1'b0;
    req = 4'b1100;
    tick();
    check("ar_regrant", 32'(grant), 32'h4);
    check("ar_regrant_id", 32'(grant_id), 32'd2);

`ifdef BUS_ARB_CONTENTION_EN
    // Contention counter: ten waiting cycles, then clear beats increment.
    rst = 1'b1;
    tick();
    check("cc_rst", 32'(contention_cnt), 32'd0);
    rst = 1'b0;
    req = 4'b0011;
    repeat (10) tick();
    check("cc_ten", 32'(contention_cnt), 32'd10);
    cnt_clr = 1'b1;
    tick();
    check("cc_clear", 32'(contention_cnt), 32'd0);
    cnt_clr = 1'b0;
    tick();
    check("cc_resume", 32'(contention_cnt), 32'd1);
`endif

    req = 4'b0000;
    tick(); tick(); tick();
    check("end_idle", 32'(bus_idle), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
